// File: rtl/capture_sequencer.sv
// Multi-channel ADC capture sequencer: decimated, masked sample writes into a
// circular RAM with pre-trigger history, external/forced triggering and trigger-pointer report.
module capture_sequencer #(
  parameter int unsigned nch = 8,
  parameter int unsigned dw  = 16,
  parameter int unsigned aw  = 14,
  parameter int unsigned cw  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [nch*dw-1:0] adc_data,
  input  logic [nch-1:0]    chan_mask,
  input  logic [cw-1:0]     dec_ratio,
  input  logic [aw-1:0]     pretrig,
  input  logic              mode,
  input  logic              arm,
  input  logic              ext_trig,
  input  logic              force_trig,
  output logic              wr_en,
  output logic [aw-1:0]     wr_addr,
  output logic [nch*dw-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [aw-1:0]     trig_ptr,
  output logic              trig_missed
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  localparam logic [aw:0] FULL = (aw+1)'(1) << aw;

  state_t              state_q, state_d;
  logic [cw-1:0]       cnt_q, cnt_d, dec_q, dec_d;
  logic [aw-1:0]       ptr_q, ptr_d, pre_rem_q, pre_rem_d, pt_q, pt_d;
  logic [aw:0]         post_rem_q, post_rem_d;
  logic [nch-1:0]      mask_q, mask_d;
  logic                pend_q, pend_d, missed_q, missed_d;
  logic [aw-1:0]       trig_ptr_q, trig_ptr_d, wr_addr_q, wr_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [nch*dw-1:0]   wr_data_q, wr_data_d, masked;
  logic                strobe, trig, do_write;

  assign strobe = (cnt_q == dec_q);
  assign trig   = ext_trig | force_trig;

  always_comb begin
    masked = '0;
    for (int unsigned k = 0; k < nch; k++) begin
      masked[k*dw +: dw] = adc_data[k*dw +: dw] & {dw{mask_q[k]}};
    end
  end

  // New ratio is picked up only when the counter wraps or a capture is armed.
  always_comb begin
    cnt_d = '0;
    dec_d = dec_q;
    if (!arm && !strobe) cnt_d = cnt_q + cw'(1);
    if (arm || strobe) dec_d = dec_ratio;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    pre_rem_d  = pre_rem_q;
    post_rem_d = post_rem_q;
    pt_d       = pt_q;
    mask_d     = mask_q;
    pend_d     = pend_q;
    missed_d   = missed_q;
    trig_ptr_d = trig_ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    do_write   = 1'b0;
    if (arm) begin
      // pretrig is aw bits wide, so it never exceeds 2^aw-1 and needs no clamp.
      ptr_d      = '0;
      missed_d   = 1'b0;
      pend_d     = 1'b0;
      mask_d     = chan_mask;
      pt_d       = pretrig;
      pre_rem_d  = pretrig;
      post_rem_d = FULL;
      trig_ptr_d = '0;
      if (!mode)               state_d = S_POST;
      else if (pretrig == '0)  state_d = S_WAIT;
      else                     state_d = S_PRE;
    end else begin
      case (state_q)
        S_PRE: begin
          if (trig) missed_d = 1'b1;
          if (strobe) begin
            do_write  = 1'b1;
            pre_rem_d = pre_rem_q - aw'(1);
            if (pre_rem_q == aw'(1)) state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (strobe) begin
            do_write = 1'b1;
            if (pend_q || trig) begin
              pend_d     = 1'b0;
              trig_ptr_d = ptr_q;
              post_rem_d = FULL - {1'b0, pt_q} - (aw+1)'(1);
              state_d    = (pt_q == '1) ? S_DONE : S_POST;
            end
          end else if (trig) begin
            pend_d = 1'b1;
          end
        end
        S_POST: begin
          if (strobe) begin
            do_write   = 1'b1;
            post_rem_d = post_rem_q - (aw+1)'(1);
            if (post_rem_q == (aw+1)'(1)) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = masked;
      ptr_d     = ptr_q + aw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dec_q      <= '0;
      ptr_q      <= '0;
      pre_rem_q  <= '0;
      post_rem_q <= '0;
      pt_q       <= '0;
      mask_q     <= '0;
      pend_q     <= 1'b0;
      missed_q   <= 1'b0;
      trig_ptr_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      ptr_q      <= ptr_d;
      pre_rem_q  <= pre_rem_d;
      post_rem_q <= post_rem_d;
      pt_q       <= pt_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      missed_q   <= missed_d;
      trig_ptr_q <= trig_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign done        = (state_q == S_DONE);
  assign trig_ptr    = trig_ptr_q;
  assign trig_missed = missed_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer (aw=4): directed scenarios plus randomized sessions
// checked every cycle against a write-count based capture model.
module tb_capture_sequencer;

  logic         clk = 1'b0;
  logic         rst, arm, mode, ext_trig, force_trig;
  logic [127:0] adc_data;
  logic [7:0]   chan_mask;
  logic [9:0]   dec_ratio;
  logic [3:0]   pretrig;
  logic         wr_en, busy, done, trig_missed;
  logic [3:0]   wr_addr, trig_ptr;
  logic [127:0] wr_data;

  int errors = 0;
  int checks = 0;

  capture_sequencer #(.nch(8), .dw(16), .aw(4), .cw(10)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .chan_mask(chan_mask),
    .dec_ratio(dec_ratio), .pretrig(pretrig), .mode(mode), .arm(arm),
    .ext_trig(ext_trig), .force_trig(force_trig), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .trig_ptr(trig_ptr), .trig_missed(trig_missed)
  );

  always #5 clk = ~clk;

  bit          adc_ramp = 1'b1;
  logic [15:0] ramp = 16'h0;
  always @(negedge clk) begin
    ramp = ramp + 16'd1;
    for (int k = 0; k < 8; k++) begin
      adc_data[k*16 +: 16] = adc_ramp ? ramp + 16'(k) : 16'($urandom);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a capture is described by how many samples were written since arm
  // and at which write index the trigger landed; phase follows from those counts.
  bit         m_valid = 1'b0, m_active, m_done, m_missed, m_pend, m_mode;
  int         m_writes, m_trig_idx, m_pt, m_dec, m_sc;
  logic [7:0] m_mask;
  logic         e_wr_en;
  logic [3:0]   e_addr, e_trig_ptr;
  logic [127:0] e_data;

  task automatic write_sample();
    e_wr_en = 1'b1;
    e_addr  = 4'(m_writes % 16);
    for (int k = 0; k < 8; k++) e_data[k*16 +: 16] = m_mask[k] ? adc_data[k*16 +: 16] : 16'h0;
    m_writes++;
  endtask

  task automatic model_step();
    bit trg, stb;
    if (rst) begin
      m_valid = 1'b1; m_active = 1'b0; m_done = 1'b0; m_missed = 1'b0;
      e_wr_en = 1'b0; e_addr = '0; e_data = '0; e_trig_ptr = '0;
      return;
    end
    if (!m_valid) return;
    e_wr_en = 1'b0;
    if (arm) begin
      m_active = 1'b1; m_done = 1'b0; m_missed = 1'b0; m_pend = 1'b0;
      m_writes = 0; m_trig_idx = -1; m_pt = int'(pretrig); m_mode = mode;
      m_mask = chan_mask; m_dec = int'(dec_ratio); m_sc = 0; e_trig_ptr = '0;
      return;
    end
    if (!m_active || m_done) return;
    trg = ext_trig || force_trig;
    stb = (m_sc % (m_dec + 1)) == m_dec;
    m_sc++;
    if (m_mode && m_writes < m_pt) begin
      if (trg) m_missed = 1'b1;
      if (stb) write_sample();
    end else if (m_mode && m_trig_idx < 0) begin
      if (stb) begin
        if (m_pend || trg) begin
          m_trig_idx = m_writes;
          e_trig_ptr = 4'(m_writes % 16);
        end
        write_sample();
      end else if (trg) m_pend = 1'b1;
    end else if (stb) write_sample();
    if (!m_mode && m_writes == 16) m_done = 1'b1;
    if (m_mode && m_trig_idx >= 0 && (m_writes - m_trig_idx) == 16 - m_pt) m_done = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      if (m_valid) begin
        chk("wr_en", wr_en, e_wr_en);
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
        chk("busy", busy, m_active && !m_done);
        chk("done", done, m_done);
        chk("trig_ptr", trig_ptr, e_trig_ptr);
        chk("trig_missed", trig_missed, m_missed);
      end
    end
  end

  task automatic do_arm(input bit md, input int pt, input int dec, input logic [7:0] msk);
    @(negedge clk);
    mode = md; pretrig = 4'(pt); dec_ratio = 10'(dec); chan_mask = msk; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int seen = 0, cyc = 0;
    while (seen < n && cyc < 500) begin
      @(posedge clk); #1; cyc++;
      if (wr_en) seen++;
    end
    chk("wait_writes_count", seen, n);
  endtask

  task automatic count_to_done(output int nwr);
    int cyc = 0;
    nwr = 0;
    while (!done && cyc < 500) begin
      @(posedge clk); #1; cyc++;
      if (wr_en) nwr++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  task automatic trig_count(input bit use_force, output int nwr);
    int extra;
    @(negedge clk);
    if (use_force) force_trig = 1'b1; else ext_trig = 1'b1;
    @(posedge clk); #1;
    nwr = wr_en ? 1 : 0;
    @(negedge clk);
    ext_trig = 1'b0; force_trig = 1'b0;
    count_to_done(extra);
    nwr += extra;
  endtask

  initial begin
    int n, bad, lat;
    rst = 1'b1; arm = 1'b0; mode = 1'b0; ext_trig = 1'b0; force_trig = 1'b0;
    chan_mask = 8'hFF; dec_ratio = '0; pretrig = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_trig_ptr", trig_ptr, 4'd0);
    rst = 1'b0;

    // Immediate capture: 16 back-to-back writes at addresses 0..15.
    do_arm(1'b0, 0, 0, 8'hFF);
    n = 0; bad = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      if (wr_en) begin
        if (wr_addr != 4'(n)) bad++;
        n++;
      end
    end
    chk("imm_writes", n, 16);
    chk("imm_addr_seq_errs", bad, 0);
    chk("imm_done", done, 1'b1);
    chk("imm_trig_ptr", trig_ptr, 4'd0);

    // Decimation by 4: first write 4 clocks after the arm edge.
    do_arm(1'b0, 0, 3, 8'hFF);
    lat = 0;
    for (int c = 0; c < 20 && !wr_en; c++) begin
      @(posedge clk); #1; lat++;
    end
    chk("dec_first_latency", lat, 4);
    count_to_done(n);
    chk("dec_writes", n + 1, 16);

    // Pre-trigger with wrap: trigger after 37 writes.
    do_arm(1'b1, 5, 0, 8'hFF);
    wait_writes(37);
    trig_count(1'b0, n);
    chk("wrap_trig_ptr", trig_ptr, 4'd5);
    chk("wrap_post_writes", n, 11);
    chk("wrap_oldest", 4'(trig_ptr - 4'd5), 4'd0);

    // Trigger inside PRE is missed; force completes the capture.
    do_arm(1'b1, 8, 0, 8'hFF);
    wait_writes(3);
    @(negedge clk); ext_trig = 1'b1;
    @(negedge clk); ext_trig = 1'b0;
    repeat (20) @(negedge clk);
    chk("miss_flag", trig_missed, 1'b1);
    chk("miss_still_busy", busy, 1'b1);
    chk("miss_not_done", done, 1'b0);
    trig_count(1'b1, n);
    chk("miss_post_writes", n, 8);

    // Clamped pretrig with channel mask.
    adc_ramp = 1'b0;
    do_arm(1'b1, 15, 1, 8'h0F);
    wait_writes(20);
    trig_count(1'b1, n);
    chk("clamp_post_writes", n, 1);
    chk("mask_upper_zero", wr_data[127:64], 64'h0);

    // Arm with a coincident trigger restarts from address 0, trigger dropped.
    do_arm(1'b1, 2, 0, 8'hFF);
    wait_writes(6);
    @(negedge clk); ext_trig = 1'b1;
    do_arm(1'b1, 2, 0, 8'hFF);
    ext_trig = 1'b0;
    @(posedge clk); #1;
    chk("rearm_first_addr", wr_addr, 4'd0);
    repeat (10) @(negedge clk);
    chk("rearm_busy", busy, 1'b1);
    chk("rearm_no_trig", done, 1'b0);

    // Reset in the middle of POST.
    do_arm(1'b0, 0, 0, 8'hFF);
    wait_writes(5);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_wr_en", wr_en, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      do_arm(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 2), 8'($urandom));
      for (int c = 0; c < 300 && !done; c++) begin
        @(negedge clk);
        ext_trig   = ($urandom % 20) == 0;
        force_trig = ($urandom % 40) == 0;
        rst        = ($urandom % 400) == 0;
        arm        = ($urandom % 200) == 0;
        if (arm) begin
          mode = 1'($urandom); pretrig = 4'($urandom);
          dec_ratio = 10'($urandom_range(0, 2)); chan_mask = 8'($urandom);
        end
      end
      @(negedge clk);
      ext_trig = 1'b0; force_trig = 1'b0; rst = 1'b0; arm = 1'b0;
      repeat (3) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
